// File: rtl/async_mmap_read_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_mmap_read_stream_pkg
// Description : Shared types and helpers for the sequential-read front end:
//               FSM state encoding and the word-index to byte-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package async_mmap_read_stream_pkg;

    // Two-state controller: waiting for a request, or streaming one.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Wide enough for any realistic address width; callers truncate.
    localparam int unsigned C_OFFSET_WIDTH = 128;

    // Byte offset of word number word_index for a word of 2**shift bytes.
    function automatic logic [C_OFFSET_WIDTH-1:0] stride_offset(
        input logic [C_OFFSET_WIDTH-1:0] word_index,
        input int unsigned               shift
    );
        return word_index << shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_mmap_read_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : async_mmap_read_stream_if
// Description : Bundles the memory port's read-address push side, its
//               read-data pop side and the registered output stream.
//               master = the read front end, slave = port plus consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface async_mmap_read_stream_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
);
    // Read-address FIFO push side
    logic [ADDR_WIDTH-1:0] read_addr_din;
    logic                  read_addr_write;
    logic                  read_addr_full_n;

    // Read-data FIFO pop side
    logic [DATA_WIDTH-1:0] read_data_dout;
    logic                  read_data_empty_n;
    logic                  read_data_read;

    // Output stream
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output read_addr_din,
        output read_addr_write,
        input  read_addr_full_n,
        input  read_data_dout,
        input  read_data_empty_n,
        output read_data_read,
        output out_data,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  read_addr_din,
        input  read_addr_write,
        output read_addr_full_n,
        output read_data_dout,
        output read_data_empty_n,
        input  read_data_read,
        input  out_data,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/async_mmap_read_stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : async_mmap_read_stream_out_reg
// Description : One-entry valid/ready output register carrying a data word
//               and its last flag. A load always wins; otherwise an accepted
//               word empties the register. Contents hold while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module async_mmap_read_stream_out_reg #(
    parameter int DATA_WIDTH = 512
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   i_load,
    input  wire                   i_ready,
    input  wire  [DATA_WIDTH-1:0] i_data,
    input  wire                   i_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_valid;

    // Capture a new word on load, drop valid once the consumer took it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/async_mmap_read_stream.sv
`default_nettype none
// ============================================================================
// Module      : async_mmap_read_stream
// Description : Sequential-read front end for the asynchronous memory-mapped
//               port. Issues count consecutive word addresses starting at
//               base_addr into the port's read-address FIFO, pops the
//               returning words into a registered stream with a last flag,
//               and limits issued-but-unpopped words to MAX_OUTSTANDING so
//               the port's read-data buffer never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module async_mmap_read_stream #(
    parameter int ADDR_WIDTH           = 64,
    parameter int DATA_WIDTH           = 512,
    parameter int DATA_WIDTH_BYTES_LOG = 6,
    parameter int COUNT_WIDTH          = 32,
    parameter int MAX_OUTSTANDING      = 64,
    parameter int OUTSTANDING_WIDTH    = 7
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    start,
    input  wire  [ADDR_WIDTH-1:0]  base_addr,
    input  wire  [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    async_mmap_read_stream_if.master mm
);

    import async_mmap_read_stream_pkg::*;

    localparam logic [OUTSTANDING_WIDTH-1:0] C_MAX_OUT = OUTSTANDING_WIDTH'(MAX_OUTSTANDING);
    localparam logic [COUNT_WIDTH-1:0]       C_ONE     = COUNT_WIDTH'(1);

    state_t                       r_state;
    logic                         r_done;
    logic [ADDR_WIDTH-1:0]        r_base;
    logic [COUNT_WIDTH-1:0]       r_count;
    logic [COUNT_WIDTH-1:0]       r_issued;
    logic [COUNT_WIDTH-1:0]       r_received;
    logic [OUTSTANDING_WIDTH-1:0] r_outstanding;

    logic w_run;
    logic w_issue;
    logic w_pop;
    logic w_last;
    logic w_final_accept;

    assign w_run = (r_state == S_RUN);

    // An address goes out while words remain, the port has room and the
    // port's read-data buffer is guaranteed space for the answer.
    assign w_issue = w_run
                  && (r_issued != r_count)
                  && mm.read_addr_full_n
                  && (r_outstanding < C_MAX_OUT);

    // A word is popped only when the output register is free or draining
    // this cycle; IDLE never pops so stray data stays in the port.
    assign w_pop = w_run
                && mm.read_data_empty_n
                && (!mm.out_valid || mm.out_ready)
                && (r_received != r_count);

    assign w_last         = (r_received == r_count - C_ONE);
    assign w_final_accept = mm.out_valid && mm.out_ready && mm.out_last;

    // Address arithmetic wraps silently at the address width.
    assign mm.read_addr_din   = r_base + ADDR_WIDTH'(stride_offset(C_OFFSET_WIDTH'(r_issued),
                                                                   DATA_WIDTH_BYTES_LOG));
    assign mm.read_addr_write = w_issue;
    assign mm.read_data_read  = w_pop;

    assign busy = w_run;
    assign done = r_done;

    // Controller: request acceptance, issue/receive/credit tracking, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_base        <= '0;
            r_count       <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            // Empty request completes without touching the port.
                            r_done <= 1'b1;
                        end else begin
                            r_base        <= base_addr;
                            r_count       <= count;
                            r_issued      <= '0;
                            r_received    <= '0;
                            r_outstanding <= '0;
                            r_state       <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_issued <= r_issued + C_ONE;
                    end
                    if (w_pop) begin
                        r_received <= r_received + C_ONE;
                    end
                    case ({w_issue, w_pop})
                        2'b10:   r_outstanding <= r_outstanding + OUTSTANDING_WIDTH'(1);
                        2'b01:   r_outstanding <= r_outstanding - OUTSTANDING_WIDTH'(1);
                        default: r_outstanding <= r_outstanding;
                    endcase
                    if (w_final_accept) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    async_mmap_read_stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_pop),
        .i_ready (mm.out_ready),
        .i_data  (mm.read_data_dout),
        .i_last  (w_last),
        .o_data  (mm.out_data),
        .o_last  (mm.out_last),
        .o_valid (mm.out_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_async_mmap_read_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_mmap_read_stream
// Description : Bench for async_mmap_read_stream. A port model answers each
//               pushed address with a word derived from that address; a
//               transfer-level model predicts strobes, addresses and the
//               output word sequence and is compared on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_mmap_read_stream;

    localparam int DW   = 512;
    localparam int AW   = 64;
    localparam int MAXO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   count = '0;
    logic          busy;
    logic          done;

    logic          full_en = 1'b1;
    logic          data_en = 1'b1;
    logic          port_has = 1'b0;
    logic [DW-1:0] port_head = '0;

    async_mmap_read_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mm ();

    assign mm.read_addr_full_n  = full_en;
    assign mm.read_data_empty_n = port_has && data_en;
    assign mm.read_data_dout    = port_head;

    async_mmap_read_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mm        (mm)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Word the port returns for a given address.
    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {a, ~a, a ^ 64'h0123_4567_89AB_CDEF, a + 64'd1,
                32'hC0DE_0000, a[31:0], a, ~a, a};
    endfunction

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- transfer-level model ----------------
    bit            m_run = 0;
    bit            m_done = 0;
    bit            m_ov = 0;
    logic [AW-1:0] m_base = '0;
    int unsigned   m_cnt = 0;
    int unsigned   m_iss = 0;
    int unsigned   m_pop = 0;
    int unsigned   m_k = 0;
    int unsigned   m_acc = 0;
    int            cyc = 0;

    logic [AW-1:0] port_q[$];
    logic [AW-1:0] push_addr[$];
    int            push_cyc[$];

    bit            mon_ew, mon_er, mon_hs, mon_nd;
    logic [AW-1:0] mon_ea;

    // Compare process: check outputs on the falling edge, advance the model
    // and the port, then present the port's next head word after the edge.
    always begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk_b("rst_busy", busy, 1'b0);
            chk_b("rst_done", done, 1'b0);
            chk_b("rst_write", mm.read_addr_write, 1'b0);
            chk_b("rst_read", mm.read_data_read, 1'b0);
            chk_b("rst_valid", mm.out_valid, 1'b0);
            chk_b("rst_last", mm.out_last, 1'b0);
            chk_w("rst_data", mm.out_data, '0);
            chk_w("rst_addr", DW'(mm.read_addr_din), '0);
            m_run = 0; m_done = 0; m_ov = 0; m_base = '0;
            m_cnt = 0; m_iss = 0; m_pop = 0;
            port_q.delete();
        end else begin
            mon_ea = m_base + (64'(m_iss) << 6);
            mon_ew = m_run && (m_iss != m_cnt) && mm.read_addr_full_n && ((m_iss - m_pop) < MAXO);
            mon_er = m_run && mm.read_data_empty_n && (!m_ov || mm.out_ready) && (m_pop != m_cnt);
            chk_b("busy", busy, m_run);
            chk_b("done", done, m_done);
            chk_b("addr_write", mm.read_addr_write, mon_ew);
            chk_b("data_read", mm.read_data_read, mon_er);
            chk_b("out_valid", mm.out_valid, m_ov);
            if (mon_ew) chk_w("addr", DW'(mm.read_addr_din), DW'(mon_ea));
            if (m_ov) begin
                chk_w("out_data", mm.out_data, data_of(m_base + (64'(m_k) << 6)));
                chk_b("out_last", mm.out_last, m_k == m_cnt - 1);
            end
            // Port reacts to what the DUT actually strobed.
            if (mm.read_data_read && port_q.size() != 0) void'(port_q.pop_front());
            if (mm.read_addr_write) begin
                port_q.push_back(mm.read_addr_din);
                push_addr.push_back(mm.read_addr_din);
                push_cyc.push_back(cyc);
            end
            mon_nd = 0;
            if (!m_run) begin
                if (start) begin
                    if (count == 0) mon_nd = 1;
                    else begin
                        m_run = 1; m_base = base_addr; m_cnt = count; m_iss = 0; m_pop = 0;
                    end
                end
            end else begin
                mon_hs = m_ov && mm.out_ready;
                if (mon_hs) m_acc++;
                if (mon_hs && (m_k == m_cnt - 1)) begin m_run = 0; mon_nd = 1; end
                if (mon_ew) m_iss++;
                if (mon_er) begin m_ov = 1; m_k = m_pop; m_pop++; end
                else if (mm.out_ready) m_ov = 0;
            end
            m_done = mon_nd;
        end
        @(posedge clk);
        #1;
        port_has  = (port_q.size() != 0);
        port_head = port_has ? data_of(port_q[0]) : '0;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [31:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name, input bit rnd);
        int n;
        n = 0;
        while (!done && n < budget) begin
            if (rnd) begin
                mm.out_ready = 1'($urandom_range(0, 1));
                full_en      = ($urandom_range(0, 3) != 0);
                data_en      = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        chk_b({name, "_done_seen"}, done, 1'b1);
        mm.out_ready = 1'b1;
        full_en      = 1'b1;
        data_en      = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int n;
        int a0;
        mm.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_b("idle_busy", busy, 1'b0);
        chk_w("idle_addr", DW'(mm.read_addr_din), '0);

        // Four words, ideal port
        push_addr.delete(); push_cyc.delete();
        s = cyc;
        do_start(64'h1000, 32'd4);
        wait_done(60, "t1", 0);
        chk_i("t1_pushes", push_addr.size(), 4);
        chk_w("t1_a0", DW'(push_addr[0]), DW'(64'h1000));
        chk_w("t1_a1", DW'(push_addr[1]), DW'(64'h1040));
        chk_w("t1_a2", DW'(push_addr[2]), DW'(64'h1080));
        chk_w("t1_a3", DW'(push_addr[3]), DW'(64'h10C0));
        chk_i("t1_first_cycle", push_cyc[0], s + 2);
        chk_i("t1_consecutive", push_cyc[3], s + 5);
        tick();

        // Zero-length request
        push_addr.delete();
        do_start(64'h2000, 32'd0);
        chk_b("t2_done", done, 1'b1);
        chk_b("t2_busy", busy, 1'b0);
        tick();
        chk_b("t2_done_pulse", done, 1'b0);
        chk_i("t2_pushes", push_addr.size(), 0);
        tick();

        // Credit limit with a silent port, then release
        push_addr.delete();
        data_en = 1'b0;
        do_start(64'h4_0000, 32'd200);
        repeat (100) tick();
        chk_i("t3_credit_pushes", push_addr.size(), MAXO);
        chk_b("t3_write_held", mm.read_addr_write, 1'b0);
        data_en = 1'b1;
        wait_done(1000, "t3", 0);
        chk_i("t3_total_pushes", push_addr.size(), 200);
        tick();

        // Random backpressure, sixteen words, then several random transfers
        do_start({$urandom(), $urandom()}, 32'd16);
        wait_done(2000, "t4", 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            do_start({$urandom(), $urandom()}, 32'($urandom_range(1, 40)));
            wait_done(2000, "t4r", 1);
            tick();
        end

        // Address wrap
        push_addr.delete();
        do_start(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
        wait_done(60, "t5", 0);
        chk_i("t5_pushes", push_addr.size(), 2);
        chk_w("t5_a0", DW'(push_addr[0]), DW'(64'hFFFF_FFFF_FFFF_FFC0));
        chk_w("t5_a1", DW'(push_addr[1]), '0);
        tick();

        // Reset after three of eight words, then a clean transfer
        a0 = int'(m_acc);
        do_start(64'h8000, 32'd8);
        n = 0;
        while (int'(m_acc) < a0 + 3 && n < 100) begin tick(); n++; end
        chk_i("t6_three_accepted", int'(m_acc) - a0, 3);
        rst = 1'b1;
        #1;
        chk_b("t6_busy", busy, 1'b0);
        chk_b("t6_valid", mm.out_valid, 1'b0);
        chk_b("t6_write", mm.read_addr_write, 1'b0);
        chk_w("t6_data", mm.out_data, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        push_addr.delete();
        do_start(64'h9000, 32'd2);
        wait_done(60, "t6", 0);
        chk_i("t6_pushes", push_addr.size(), 2);
        chk_w("t6_a1", DW'(push_addr[1]), DW'(64'h9040));
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
